// File: rtl/pattern_scan_ctrl_if.sv
// Byte-stream, configuration and status signals of the pattern scanner.
// The master drives the bytes and the pattern writes; the slave is the scanner.
interface pattern_scan_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_we;
  logic [4:0]       cfg_pattern;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic             busy;
  logic             p_det;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_we, cfg_pattern, in_valid, in_byte,
    input  in_ready, busy, p_det, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_pattern, in_valid, in_byte,
    output in_ready, busy, p_det, match_cnt
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial 5-bit pattern detector fed one byte at a time, MSB first.
// Define MATCH_CNT_EN to build the saturating detection counter; otherwise match_cnt is 0.
//
// state | meaning
// IDLE  | waiting for a byte handshake; pattern writes accepted
// SHIFT | shifting the captured byte into the history, one bit per clock
module pattern_scan_ctrl #(
  parameter logic [4:0] PAT_DEFAULT = 5'b10110,
  parameter int         CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] byte_q;
  logic [2:0] bit_idx;
  logic [4:0] hist;
  logic [4:0] pattern;
  logic [2:0] fill;
  logic       p_det_q;

  logic [4:0] hist_nxt;
  logic [2:0] fill_nxt;
  logic       hit;

  // History and fill carry over between bytes so matches can straddle them.
  always_comb begin
    hist_nxt = {hist[3:0], byte_q[bit_idx]};
    fill_nxt = (fill == 3'd5) ? fill : fill + 3'd1;
    hit      = (state == SHIFT) && (fill_nxt == 3'd5) && (hist_nxt == pattern);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      byte_q  <= '0;
      bit_idx <= '0;
      hist    <= '0;
      fill    <= '0;
      pattern <= PAT_DEFAULT;
      p_det_q <= 1'b0;
    end else begin
      p_det_q <= hit;
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            pattern <= bus.cfg_pattern;
            hist    <= '0;
            fill    <= '0;
          end
          if (bus.in_valid) begin
            byte_q  <= bus.in_byte;
            bit_idx <= 3'd7;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          hist <= hist_nxt;
          fill <= fill_nxt;
          if (bit_idx == 3'd0) begin
            state <= IDLE;
          end else begin
            bit_idx <= bit_idx - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state == SHIFT);
  assign bus.p_det    = p_det_q;

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if ((state == IDLE) && bus.cfg_we) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule
